// File: rtl/prog_loader_pkg.sv
// Shared types and header field layout for the cpu4 program loader.
package prog_loader_pkg;

  // Header command field encoding
  typedef enum logic [1:0] {
    CMD_IMEM = 2'b00,
    CMD_DMEM = 2'b01,
    CMD_RSVD = 2'b10,
    CMD_GO   = 2'b11
  } cmd_e;

  // Loader / run-controller states
  typedef enum logic [2:0] {
    ST_HDR     = 3'd0,
    ST_DATA    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_e;

  // Header word bit positions
  localparam int HDR_CMD_HI  = 31;
  localparam int HDR_CMD_LO  = 30;
  localparam int HDR_BASE_HI = 29;
  localparam int HDR_BASE_LO = 16;
  localparam int HDR_CNT_HI  = 15;
  localparam int HDR_CNT_LO  = 0;
  localparam int HDR_BASE_W  = HDR_BASE_HI - HDR_BASE_LO + 1;
  localparam int HDR_CNT_W   = HDR_CNT_HI - HDR_CNT_LO + 1;

endpackage

// File: rtl/prog_loader.sv
// Program loader and run controller for cpu4: decodes a header/payload word
// stream into memory writes with the CPU held in reset, then releases the CPU
// on GO and counts run cycles until halt or exception.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int RELEASE_DLY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_,
  input  logic              cpu_halt,
  input  logic              cpu_exception,
  output logic [31:0]       cycle_count,
  output logic              done,
  output logic              error
);

  // Release delay counter only needs to reach RELEASE_DLY-1
  localparam int DLY_W = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RELEASE_DLY - 1);

  state_e                state_reg, state_next;
  logic                  is_dmem_reg, is_dmem_next;
  logic [ADDR_W-1:0]     addr_reg, addr_next;
  logic [HDR_CNT_W-1:0]  remaining_reg, remaining_next;
  logic [DLY_W-1:0]      dly_reg, dly_next;
  logic                  in_ready_reg, in_ready_next;
  logic                  imem_we_reg, imem_we_next;
  logic                  dmem_we_reg, dmem_we_next;
  logic [ADDR_W-1:0]     mem_addr_reg, mem_addr_next;
  logic [31:0]           mem_wdata_reg, mem_wdata_next;
  logic                  cpu_rst_reg, cpu_rst_next;
  logic [31:0]           cycle_count_reg, cycle_count_next;
  logic                  done_reg, done_next;
  logic                  error_reg, error_next;

  logic                  accept;
  cmd_e                  hdr_cmd;
  logic [HDR_BASE_W-1:0] hdr_base;
  logic [HDR_CNT_W-1:0]  hdr_cnt;
  logic                  base_oor;

  assign accept   = in_valid & in_ready_reg;
  assign hdr_cmd  = cmd_e'(in_data[HDR_CMD_HI:HDR_CMD_LO]);
  assign hdr_base = in_data[HDR_BASE_HI:HDR_BASE_LO];
  assign hdr_cnt  = in_data[HDR_CNT_HI:HDR_CNT_LO];
  // Any base bit above the memory address width makes the header illegal
  assign base_oor = (hdr_base >> ADDR_W) != '0;

  // Next-state and registered-output decode
  always_comb begin
    state_next       = state_reg;
    is_dmem_next     = is_dmem_reg;
    addr_next        = addr_reg;
    remaining_next   = remaining_reg;
    dly_next         = dly_reg;
    imem_we_next     = 1'b0;
    dmem_we_next     = 1'b0;
    mem_addr_next    = mem_addr_reg;
    mem_wdata_next   = mem_wdata_reg;
    cpu_rst_next     = cpu_rst_reg;
    cycle_count_next = cycle_count_reg;
    done_next        = done_reg;
    error_next       = error_reg;

    case (state_reg)
      ST_HDR: begin
        if (accept) begin
          case (hdr_cmd)
            CMD_IMEM, CMD_DMEM: begin
              if (base_oor) begin
                state_next = ST_ERR;
                error_next = 1'b1;
              end else if (hdr_cnt != '0) begin
                state_next     = ST_DATA;
                is_dmem_next   = (hdr_cmd == CMD_DMEM);
                addr_next      = hdr_base[ADDR_W-1:0];
                remaining_next = hdr_cnt;
              end
            end
            CMD_GO: begin
              state_next = ST_RELEASE;
              dly_next   = '0;
            end
            default: begin
              state_next = ST_ERR;
              error_next = 1'b1;
            end
          endcase
        end
      end
      ST_DATA: begin
        if (accept) begin
          imem_we_next   = ~is_dmem_reg;
          dmem_we_next   = is_dmem_reg;
          mem_addr_next  = addr_reg;
          mem_wdata_next = in_data;
          addr_next      = addr_reg + ADDR_W'(1);
          remaining_next = remaining_reg - HDR_CNT_W'(1);
          if (remaining_reg == HDR_CNT_W'(1)) begin
            state_next = ST_HDR;
          end
        end
      end
      ST_RELEASE: begin
        if (dly_reg == DLY_LAST) begin
          cpu_rst_next = 1'b1;
          state_next   = ST_RUN;
        end else begin
          dly_next = dly_reg + DLY_W'(1);
        end
      end
      ST_RUN: begin
        if (cycle_count_reg != 32'hFFFF_FFFF) begin
          cycle_count_next = cycle_count_reg + 32'd1;
        end
        if (cpu_halt) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else if (cpu_exception) begin
          state_next = ST_ERR;
          error_next = 1'b1;
        end
      end
      ST_DONE, ST_ERR: begin
        state_next = state_reg;
      end
      default: begin
        state_next = ST_ERR;
        error_next = 1'b1;
      end
    endcase

    in_ready_next = (state_next == ST_HDR) || (state_next == ST_DATA);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_HDR;
      is_dmem_reg     <= 1'b0;
      addr_reg        <= '0;
      remaining_reg   <= '0;
      dly_reg         <= '0;
      in_ready_reg    <= 1'b1;
      imem_we_reg     <= 1'b0;
      dmem_we_reg     <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      cpu_rst_reg     <= 1'b0;
      cycle_count_reg <= '0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      is_dmem_reg     <= is_dmem_next;
      addr_reg        <= addr_next;
      remaining_reg   <= remaining_next;
      dly_reg         <= dly_next;
      in_ready_reg    <= in_ready_next;
      imem_we_reg     <= imem_we_next;
      dmem_we_reg     <= dmem_we_next;
      mem_addr_reg    <= mem_addr_next;
      mem_wdata_reg   <= mem_wdata_next;
      cpu_rst_reg     <= cpu_rst_next;
      cycle_count_reg <= cycle_count_next;
      done_reg        <= done_next;
      error_reg       <= error_next;
    end
  end

  assign in_ready    = in_ready_reg;
  assign imem_we     = imem_we_reg;
  assign dmem_we     = dmem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign cpu_rst_    = cpu_rst_reg;
  assign cycle_count = cycle_count_reg;
  assign done        = done_reg;
  assign error       = error_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Scenario bench for prog_loader: expected memory writes come from a list of
// (target, base+i mod 256, word) built as each load is issued; run timing is
// checked against edge counts kept by the bench.
module tb_prog_loader;

  localparam int ADDR_W = 8;
  localparam int DLY    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              imem_we;
  logic              dmem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst_;
  logic              cpu_halt;
  logic              cpu_exception;
  logic [31:0]       cycle_count;
  logic              done;
  logic              error;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic              is_dmem;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [31:0]       cyc;
  } wr_t;

  wr_t         obs_q[$];
  wr_t         exp_q[$];
  logic [31:0] cyc_n = 0;
  logic [31:0] word_src[16];

  prog_loader #(.ADDR_W(ADDR_W), .RELEASE_DLY(DLY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .imem_we(imem_we), .dmem_we(dmem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst_(cpu_rst_),
    .cpu_halt(cpu_halt), .cpu_exception(cpu_exception),
    .cycle_count(cycle_count), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Write monitor: record every strobe seen mid-cycle
  always @(negedge clk) begin
    cyc_n <= cyc_n + 1;
    if (imem_we || dmem_we) begin
      obs_q.push_back('{is_dmem: dmem_we, addr: mem_addr, data: mem_wdata, cyc: cyc_n});
      if (imem_we && dmem_we) begin
        tests++;
        fails++;
        $display("FAIL both_strobes addr=%h imem_we=%b dmem_we=%b exp one-hot", mem_addr, imem_we, dmem_we);
      end
    end
  end

  task automatic send(input logic [31:0] w);
    bit ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ok = 1;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout word=%h in_ready=%b exp 1 within 50 cycles", w, in_ready);
    end
  endtask

  // Header + n payload words from word_src, gap idle cycles between words
  task automatic load(input bit dmem, input int base, input int n, input int gap);
    send({1'b0, dmem, 14'(base), 16'(n)});
    for (int i = 0; i < n; i++) begin
      if (gap > 0 && i > 0) repeat (gap) @(negedge clk);
      send(word_src[i]);
      exp_q.push_back('{is_dmem: dmem, addr: ADDR_W'(base + i), data: word_src[i], cyc: 32'd0});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    cpu_halt = 1'b0;
    cpu_exception = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if (imem_we !== 1'b0) begin fails++; $display("FAIL reset_imem_we got=%b exp=0", imem_we); end
    tests++; if (dmem_we !== 1'b0) begin fails++; $display("FAIL reset_dmem_we got=%b exp=0", dmem_we); end
    tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL reset_mem_addr got=%h exp=00", mem_addr); end
    tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    tests++; if (cpu_rst_ !== 1'b0) begin fails++; $display("FAIL reset_cpu_rst_ got=%b exp=0", cpu_rst_); end
    tests++; if (cycle_count !== 32'h0) begin fails++; $display("FAIL reset_cycle_count got=%0d exp=0", cycle_count); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error got=%b exp=0", error); end
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_imem_b2b();
    do_reset();
    word_src[0] = 32'h1111_1111;
    word_src[1] = 32'h2222_2222;
    word_src[2] = 32'h3333_3333;
    load(1'b0, 'h10, 3, 0);
    repeat (3) @(negedge clk);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if ({obs_q[i].is_dmem, obs_q[i].addr, obs_q[i].data} !== {exp_q[i].is_dmem, exp_q[i].addr, exp_q[i].data}) begin
        fails++; $display("FAIL b2b_write%0d got=%b/%h/%h exp=%b/%h/%h", i, obs_q[i].is_dmem, obs_q[i].addr,
                          obs_q[i].data, exp_q[i].is_dmem, exp_q[i].addr, exp_q[i].data);
      end
      if (i > 0) begin
        tests++;
        if (obs_q[i].cyc !== obs_q[0].cyc + i) begin
          fails++; $display("FAIL b2b_cycle%0d got=%0d exp=%0d", i, obs_q[i].cyc, obs_q[0].cyc + i);
        end
      end
    end
    $display("[TB] imem back-to-back: %0d writes", obs_q.size());
  endtask

  task automatic test_dmem_wrap();
    do_reset();
    word_src[0] = 32'hA5A5_0001;
    word_src[1] = 32'hA5A5_0002;
    word_src[2] = 32'hC000_0000;  // GO pattern: must be taken as payload
    load(1'b1, 'hFE, 3, 1);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL wrap_in_ready got=%b exp=1", in_ready); end
    load(1'b0, 'h05, 0, 0);
    word_src[0] = 32'h0BAD_F00D;
    load(1'b1, 'h30, 1, 0);
    repeat (3) @(negedge clk);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL wrap_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if ({obs_q[i].is_dmem, obs_q[i].addr, obs_q[i].data} !== {exp_q[i].is_dmem, exp_q[i].addr, exp_q[i].data}) begin
        fails++; $display("FAIL wrap_write%0d got=%b/%h/%h exp=%b/%h/%h", i, obs_q[i].is_dmem, obs_q[i].addr,
                          obs_q[i].data, exp_q[i].is_dmem, exp_q[i].addr, exp_q[i].data);
      end
    end
    $display("[TB] dmem wrap: %0d writes", obs_q.size());
  endtask

  task automatic test_random_loads();
    do_reset();
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(0, 8);
      for (int i = 0; i < 16; i++) word_src[i] = $urandom;
      load(bit'($urandom_range(0, 1)), $urandom_range(0, 255), n, $urandom_range(0, 2));
    end
    repeat (3) @(negedge clk);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if ({obs_q[i].is_dmem, obs_q[i].addr, obs_q[i].data} !== {exp_q[i].is_dmem, exp_q[i].addr, exp_q[i].data}) begin
        fails++; $display("FAIL rand_write%0d got=%b/%h/%h exp=%b/%h/%h", i, obs_q[i].is_dmem, obs_q[i].addr,
                          obs_q[i].data, exp_q[i].is_dmem, exp_q[i].addr, exp_q[i].data);
      end
    end
    $display("[TB] random loads: %0d writes", obs_q.size());
  endtask

  task automatic test_go_run();
    int n_run = 0;
    do_reset();
    send(32'h0010_0000);  // IMEM, N=0
    send(32'hFFFF_FFFF);  // GO with junk base/count
    tests++;
    if ({in_ready, cpu_rst_} !== 2'b00) begin
      fails++; $display("FAIL go_accept in_ready/cpu_rst_ got=%b%b exp=00", in_ready, cpu_rst_);
    end
    for (int i = 1; i <= DLY; i++) begin
      @(posedge clk); #1;
      tests++;
      if (cpu_rst_ !== (i == DLY)) begin
        fails++; $display("FAIL release_edge%0d cpu_rst_ got=%b exp=%b", i, cpu_rst_, (i == DLY));
      end
    end
    repeat (99) begin @(posedge clk); #1; n_run++; end
    tests++;
    if ({done, cycle_count} !== {1'b0, 32'(n_run)}) begin
      fails++; $display("FAIL run_count99 done/count got=%b/%0d exp=0/%0d", done, cycle_count, n_run);
    end
    cpu_halt = 1'b1;
    cpu_exception = 1'b1;
    @(posedge clk); #1; n_run++;
    cpu_halt = 1'b0;
    cpu_exception = 1'b0;
    tests++;
    if ({done, error, cpu_rst_, cycle_count} !== {1'b1, 1'b0, 1'b1, 32'(n_run)}) begin
      fails++; $display("FAIL halt done/error/cpu_rst_/count got=%b/%b/%b/%0d exp=1/0/1/%0d",
                        done, error, cpu_rst_, cycle_count, n_run);
    end
    repeat (5) @(posedge clk); #1;
    tests++;
    if ({done, in_ready, cycle_count} !== {1'b1, 1'b0, 32'd100}) begin
      fails++; $display("FAIL frozen done/in_ready/count got=%b/%b/%0d exp=1/0/100", done, in_ready, cycle_count);
    end
    tests++;
    if (obs_q.size() !== 0) begin fails++; $display("FAIL go_no_writes got=%0d exp=0", obs_q.size()); end
    $display("[TB] go/run/halt: cycle_count=%0d", cycle_count);
  endtask

  task automatic test_exception();
    int m;
    do_reset();
    m = $urandom_range(1, 40);
    send(32'hC123_4567);
    repeat (DLY) @(posedge clk); #1;
    tests++;
    if (cpu_rst_ !== 1'b1) begin fails++; $display("FAIL exc_release cpu_rst_ got=%b exp=1", cpu_rst_); end
    repeat (m - 1) @(posedge clk);
    #1;
    cpu_exception = 1'b1;
    @(posedge clk); #1;
    cpu_exception = 1'b0;
    repeat (3) @(posedge clk); #1;
    tests++;
    if ({error, done, cpu_rst_, cycle_count} !== {1'b1, 1'b0, 1'b1, 32'(m)}) begin
      fails++; $display("FAIL exception error/done/cpu_rst_/count got=%b/%b/%b/%0d exp=1/0/1/%0d",
                        error, done, cpu_rst_, cycle_count, m);
    end
    do_reset();
    tests++;
    if ({cpu_rst_, error, cycle_count} !== {1'b0, 1'b0, 32'd0}) begin
      fails++; $display("FAIL exc_reset cpu_rst_/error/count got=%b/%b/%0d exp=0/0/0", cpu_rst_, error, cycle_count);
    end
    $display("[TB] exception after %0d run cycles", m);
  endtask

  task automatic test_proto_err();
    logic [31:0] hdrs[2];
    hdrs[0] = 32'h8000_0000;  // reserved command
    hdrs[1] = 32'h0100_0003;  // IMEM, base 0x100 out of range
    for (int h = 0; h < 2; h++) begin
      do_reset();
      send(hdrs[h]);
      repeat (2) @(posedge clk); #1;
      tests++;
      if ({error, done, cpu_rst_, in_ready} !== 4'b1000) begin
        fails++; $display("FAIL proto_err%0d error/done/cpu_rst_/in_ready got=%b%b%b%b exp=1000",
                          h, error, done, cpu_rst_, in_ready);
      end
      tests++;
      if (obs_q.size() !== 0) begin fails++; $display("FAIL proto_err%0d_writes got=%0d exp=0", h, obs_q.size()); end
      do_reset();
      tests++;
      if ({in_ready, imem_we, dmem_we, mem_addr, mem_wdata, cpu_rst_, cycle_count, done, error} !==
          {1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
        fails++; $display("FAIL proto_err%0d_reset ready=%b we=%b%b addr=%h wdata=%h cpu_rst_=%b cnt=%0d done=%b err=%b",
                          h, in_ready, imem_we, dmem_we, mem_addr, mem_wdata, cpu_rst_, cycle_count, done, error);
      end
      $display("[TB] protocol error header %h", hdrs[h]);
    end
  endtask

  task automatic test_rst_mid_data();
    do_reset();
    word_src[0] = 32'hDEAD_0000;
    word_src[1] = 32'hDEAD_0001;
    send(32'h0020_0005);  // IMEM base 0x20, N=5
    send(word_src[0]);
    send(word_src[1]);
    exp_q.push_back('{is_dmem: 1'b0, addr: 8'h20, data: word_src[0], cyc: 32'd0});
    exp_q.push_back('{is_dmem: 1'b0, addr: 8'h21, data: word_src[1], cyc: 32'd0});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    word_src[0] = 32'hABCD_0123;
    load(1'b0, 'h40, 1, 0);
    word_src[0] = 32'h5555_AAAA;
    load(1'b1, 'h05, 1, 0);
    repeat (3) @(negedge clk);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL rstmid_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if ({obs_q[i].is_dmem, obs_q[i].addr, obs_q[i].data} !== {exp_q[i].is_dmem, exp_q[i].addr, exp_q[i].data}) begin
        fails++; $display("FAIL rstmid_write%0d got=%b/%h/%h exp=%b/%h/%h", i, obs_q[i].is_dmem, obs_q[i].addr,
                          obs_q[i].data, exp_q[i].is_dmem, exp_q[i].addr, exp_q[i].data);
      end
    end
    $display("[TB] reset mid-data: %0d writes", obs_q.size());
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    cpu_halt = 1'b0;
    cpu_exception = 1'b0;
    test_reset();
    test_imem_b2b();
    test_dmem_wrap();
    test_random_loads();
    test_go_run();
    test_exception();
    test_proto_err();
    test_rst_mid_data();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
